match_controller: RTL

Sequences a Pong match around the ball_fsm, paddle and game_logic datapath.
- Owns both scores, the serve countdown and ball re-centring.
- Drives the freeze/hold of the playfield and detects match end.
- Sits between main_fsm (enable_game, enter) and the game datapath. Consumes point pulses from game_logic; drives the datapath reset and hold controls.

---
 rtl/match_controller_pkg.sv | 20 ++
 rtl/match_controller_tick_countdown.sv | 34 +++
 rtl/match_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/match_controller_pkg.sv
// Shared types and defaults for the Pong match sequencer.
// State encodings, winner codes and default match parameters.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_DELAY = 60;

endpackage

// File: rtl/match_controller_tick_countdown.sv
// Frame-tick countdown used to hold the ball centred before a serve.
// Loads LOAD_VAL, counts down on enabled ticks, stops at zero.
module tick_countdown #(
  parameter int LOAD_VAL = 60
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  input  logic tick,
  output logic zero
);

  localparam int W = $clog2(LOAD_VAL + 1);
  localparam logic [W-1:0] LOAD_V = W'(LOAD_VAL);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_V;
    else if (enable && tick && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: scores, serve countdown, playfield hold
// and match-end detection between main_fsm and the game datapath.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE         = DEF_WIN_SCORE,
  parameter int SERVE_DELAY_TICKS = DEF_SERVE_DELAY,
  parameter int SCORE_W           = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick_game,
  input  logic               enable_game,
  input  logic               enter,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               ball_reset,
  output logic               freeze,
  output logic               serve_dir,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  state_e             state_d, state_q;
  logic [SCORE_W-1:0] s1_d, s1_q, s2_d, s2_q;
  logic               dir_d, dir_q;
  logic [1:0]         win_d, win_q;
  logic               br_d, br_q, frz_d, frz_q, go_d, go_q;
  logic               prev_d, prev_q, rise_d, rise_q;
  logic               cd_load, cd_zero;

  tick_countdown #(.LOAD_VAL(SERVE_DELAY_TICKS)) u_cd (
    .clock  (clock),
    .reset  (reset),
    .load   (cd_load),
    .enable (enable_game && state_q == SERVE_WAIT),
    .tick   (tick_game),
    .zero   (cd_zero)
  );

  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    cd_load = 1'b0;
    prev_d  = enter;
    rise_d  = enter && !prev_q;
    unique case (state_q)
      IDLE: begin
        s1_d  = '0;
        s2_d  = '0;
        win_d = WIN_NONE;
        if (enable_game) begin
          state_d = SERVE_WAIT;
          cd_load = 1'b1;
        end
      end
      SERVE_WAIT: begin
        if (enable_game && cd_zero)
          state_d = PLAY;
      end
      PLAY: begin
        if (enable_game && (point_p1 || point_p2)) begin
          state_d = POINT;
          if (point_p1 && !point_p2) begin
            if (s1_q < WIN_V) s1_d = s1_q + SCORE_W'(1);
            dir_d = 1'b0;
          end else if (point_p2 && !point_p1) begin
            if (s2_q < WIN_V) s2_d = s2_q + SCORE_W'(1);
            dir_d = 1'b1;
          end
        end
      end
      POINT: begin
        if (s1_q == WIN_V) begin
          state_d = GAME_OVER;
          win_d   = WIN_P1;
        end else if (s2_q == WIN_V) begin
          state_d = GAME_OVER;
          win_d   = WIN_P2;
        end else begin
          state_d = SERVE_WAIT;
          cd_load = 1'b1;
        end
      end
      GAME_OVER: begin
        // rise_q lags enter by one cycle, so exit is one edge later
        if (rise_q) begin
          state_d = IDLE;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = WIN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    br_d  = (state_d != PLAY);
    frz_d = (state_d != PLAY) || !enable_game;
    go_d  = (state_d == GAME_OVER);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      dir_q   <= 1'b0;
      win_q   <= WIN_NONE;
      br_q    <= 1'b1;
      frz_q   <= 1'b1;
      go_q    <= 1'b0;
      prev_q  <= 1'b1;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      br_q    <= br_d;
      frz_q   <= frz_d;
      go_q    <= go_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign score_p1   = s1_q;
  assign score_p2   = s2_q;
  assign ball_reset = br_q;
  assign freeze     = frz_q;
  assign serve_dir  = dir_q;
  assign game_over  = go_q;
  assign winner     = win_q;

endmodule
